stream_pkt_src: RTL

- Packet transmitter that drives a valid/busy stream (v, d, busy) into downstream pipeline stages such as skid/shadow registers, FIFOs or sinks.
- A command supplies a base value and a beat count. The block emits an incrementing word sequence with a last flag and obeys downstream busy.
- It reports completion and per-packet stall statistics.
- Used as the stream source for datapath bring-up and for throughput and backpressure measurement.

---
 rtl/stream_pkt_src.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/stream_pkt_src.sv
// Command-driven packet source: emits len incrementing words from base on a valid/busy stream,
// pulses done after the last beat and reports stall cycles of the current/last packet.
module stream_pkt_src #(
  parameter int unsigned D_W = 32,
  parameter int unsigned L_W = 16,
  parameter int unsigned S_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_v,
  input  logic [L_W-1:0] cmd_len,
  input  logic [D_W-1:0] cmd_base,
  output logic           cmd_b,
  output logic           o_v,
  output logic [D_W-1:0] o_d,
  output logic           o_last,
  input  logic           o_b,
  output logic           done,
  output logic [S_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e         state_q, state_d;
  logic [L_W-1:0] len_q, len_d;
  logic [L_W-1:0] idx_q, idx_d;
  logic           o_v_q, o_v_d;
  logic [D_W-1:0] o_d_q, o_d_d;
  logic           o_last_q, o_last_d;
  logic           cmd_b_q, cmd_b_d;
  logic           done_q, done_d;
  logic [S_W-1:0] stall_q, stall_d;

  logic cmd_acc;
  logic beat_acc;
  logic beat_stall;

  assign cmd_acc    = cmd_v && !cmd_b_q && (state_q == StIdle);
  assign beat_acc   = o_v_q && !o_b;
  assign beat_stall = o_v_q && o_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      idx_q    <= '0;
      o_v_q    <= 1'b0;
      o_d_q    <= '0;
      o_last_q <= 1'b0;
      cmd_b_q  <= 1'b0;
      done_q   <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      o_v_q    <= o_v_d;
      o_d_q    <= o_d_d;
      o_last_q <= o_last_d;
      cmd_b_q  <= cmd_b_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          state_d = (cmd_len != '0) ? StSend : StDone;
        end
      end
      StSend: begin
        if (beat_acc && o_last_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d    = len_q;
    idx_d    = idx_q;
    o_v_d    = o_v_q;
    o_d_d    = o_d_q;
    o_last_d = o_last_q;
    cmd_b_d  = cmd_b_q;
    done_d   = 1'b0;
    stall_d  = stall_q;
    unique case (state_q)
      StIdle: begin
        cmd_b_d = 1'b0;
        if (cmd_acc) begin
          cmd_b_d = 1'b1;
          stall_d = '0;
          if (cmd_len != '0) begin
            len_d    = cmd_len;
            idx_d    = '0;
            o_v_d    = 1'b1;
            o_d_d    = cmd_base;
            o_last_d = (cmd_len == L_W'(1));
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (beat_stall) begin
          if (stall_q != {S_W{1'b1}}) begin
            stall_d = stall_q + S_W'(1);
          end
        end else if (beat_acc) begin
          if (o_last_q) begin
            o_v_d    = 1'b0;
            o_last_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            idx_d    = idx_q + L_W'(1);
            o_d_d    = o_d_q + D_W'(1);
            // idx_q < len_q - 1 here, so idx_q + 2 cannot wrap
            o_last_d = ((idx_q + L_W'(2)) == len_q);
          end
        end
      end
      StDone: begin
        cmd_b_d = 1'b0;
      end
      default: begin
        cmd_b_d = 1'b0;
        o_v_d   = 1'b0;
      end
    endcase
  end

  assign cmd_b     = cmd_b_q;
  assign o_v       = o_v_q;
  assign o_d       = o_d_q;
  assign o_last    = o_last_q;
  assign done      = done_q;
  assign stall_cnt = stall_q;

endmodule
